// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer
//   Execute-stage sequencer for the multicycle multiply/divide unit.
//   Decodes R-type mul (ALU op 00110) / div (ALU op 00111), fires a one-cycle
//   start pulse, holds the pipeline stall while the unit works, and presents a
//   single writeback beat: the result to rd, or a status code to $r30 when the
//   unit reports an exception or the operation times out.
//
// Ports
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   valid_in, q_imem          execute-stage instruction and its valid
//   flush                     squash the in-flight operation
//   md_ready/md_exception/    multdiv completion pulse, exception flag and
//   md_result                 result (flag/result qualified by md_ready)
//   ctrl_MULT, ctrl_DIV       registered start pulses to multdiv
//   stall                     freeze fetch/decode/execute latches
//   wb_valid, wb_rd, wb_data  one-cycle writeback beat

module multdiv_sequencer #(
   parameter int TIMEOUT     = 40,
   parameter int RSTATUS_MUL = 4,
   parameter int RSTATUS_DIV = 5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        valid_in,
   input  logic [31:0] q_imem,
   input  logic        flush,
   input  logic        md_ready,
   input  logic        md_exception,
   input  logic [31:0] md_result,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int                CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]       ST_MUL  = 32'(RSTATUS_MUL);
   localparam logic [31:0]       ST_DIV  = 32'(RSTATUS_DIV);
   localparam logic [4:0]        R_STAT  = 5'd30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [4:0]       rd_q;
   logic             div_q;

   // decode
   logic [4:0] opcode;
   logic [4:0] alu_op;
   logic       is_md;
   logic       is_div;

   assign opcode = q_imem[31:27];
   assign alu_op = q_imem[6:2];
   assign is_md  = valid_in && (opcode == 5'b00000) &&
                   ((alu_op == 5'b00110) || (alu_op == 5'b00111));
   assign is_div = alu_op[0];

   // rs/rt/shamt and the low bits play no part in sequencing
   logic unused_bits;
   assign unused_bits = ^{q_imem[21:7], q_imem[1:0]};

   // Stall rises in the decode cycle itself so the instruction is held in
   // execute while the start pulse is registered.
   assign stall = (state == BUSY) ||
                  ((state == IDLE) && is_md && !flush);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_q      <= '0;
         div_q     <= 1'b0;
         ctrl_MULT <= 1'b0;
         ctrl_DIV  <= 1'b0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
      end else begin
         // pulses default low; wb_rd/wb_data hold
         ctrl_MULT <= 1'b0;
         ctrl_DIV  <= 1'b0;
         wb_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (is_md && !flush) begin
                  rd_q      <= q_imem[26:22];
                  div_q     <= is_div;
                  cnt       <= '0;
                  ctrl_MULT <= !is_div;
                  ctrl_DIV  <= is_div;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
               // cnt==0 marks the start-pulse cycle, where md_ready is stale
               if (flush) begin
                  state <= IDLE;
               end else if (md_ready && (cnt != '0)) begin
                  wb_valid <= 1'b1;
                  state    <= DONE;
                  if (md_exception) begin
                     wb_rd   <= R_STAT;
                     wb_data <= div_q ? ST_DIV : ST_MUL;
                  end else begin
                     wb_rd   <= rd_q;
                     wb_data <= md_result;
                  end
               end else if (cnt == CNT_MAX) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= R_STAT;
                  wb_data  <= div_q ? ST_DIV : ST_MUL;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer
//   Directed bench. Each test loads a small program (instruction, multdiv
//   latency in BUSY cycles, exception flag, result, flush BUSY cycle) and
//   runs it cycle by cycle: the instruction stays in execute while stall is
//   high, and a tiny multdiv stand-in answers relative to the start pulse.
//   Traces of every output are then compared to hand-computed values.

module tb_multdiv_sequencer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [31:0] q_imem;
   logic        flush;
   logic        md_ready;
   logic        md_exception;
   logic [31:0] md_result;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   multdiv_sequencer #(.TIMEOUT(40), .RSTATUS_MUL(4), .RSTATUS_DIV(5)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .valid_in     (valid_in),
      .q_imem       (q_imem),
      .flush        (flush),
      .md_ready     (md_ready),
      .md_exception (md_exception),
      .md_result    (md_result),
      .ctrl_MULT    (ctrl_MULT),
      .ctrl_DIV     (ctrl_DIV),
      .stall        (stall),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
      mk = {op, rd, 5'd6, 5'd7, 5'd0, alu, 2'b00};
   endfunction

   // program
   logic [31:0] p_ins [8];
   int          p_lat [8];
   logic        p_exc [8];
   logic [31:0] p_res [8];
   int          p_fl  [8];
   int          p_n;
   int          rst_at;

   // traces
   logic [63:0] stall_tr, mul_tr, div_tr, wbv_tr;
   logic [4:0]  rd_tr  [64];
   logic [31:0] dat_tr [64];

   task automatic clear_prog();
      p_n    = 0;
      rst_at = -1;
   endtask

   task automatic add_op(input logic [31:0] ins, input int lat, input logic exc,
                         input logic [31:0] res, input int fl);
      p_ins[p_n] = ins;
      p_lat[p_n] = lat;
      p_exc[p_n] = exc;
      p_res[p_n] = res;
      p_fl[p_n]  = fl;
      p_n++;
   endtask

   task automatic run(input int ncyc);
      int pc, bstart, bop;
      logic rdy, fl_now;
      pc = 0; bop = -1; bstart = 0;
      stall_tr = '0; mul_tr = '0; div_tr = '0; wbv_tr = '0;
      for (int c = 0; c < ncyc; c++) begin
         rdy = 1'b0; fl_now = 1'b0;
         if (bop >= 0) begin
            rdy    = (p_lat[bop] != 0) && (c == bstart + p_lat[bop] - 1);
            fl_now = (p_fl[bop] != 0)  && (c == bstart + p_fl[bop] - 1);
         end
         reset_n      = (c == rst_at) ? 1'b0 : 1'b1;
         valid_in     = (pc < p_n);
         q_imem       = (pc < p_n) ? p_ins[pc] : 32'd0;
         md_ready     = rdy;
         md_exception = rdy ? p_exc[bop] : 1'b1;
         md_result    = rdy ? p_res[bop] : 32'hDEADBEEF;
         flush        = fl_now;
         #3;
         stall_tr[c] = stall;
         mul_tr[c]   = ctrl_MULT;
         div_tr[c]   = ctrl_DIV;
         wbv_tr[c]   = wb_valid;
         rd_tr[c]    = wb_rd;
         dat_tr[c]   = wb_data;
         if (ctrl_MULT || ctrl_DIV) begin
            bstart = c;
            bop    = pc;
         end
         if (c == rst_at)              pc = p_n;
         else if (fl_now)              pc++;
         else if (!stall && pc < p_n)  pc++;
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      reset_n = 1'b0; valid_in = 1'b0; q_imem = '0; flush = 1'b0;
      md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_ctrl",  {ctrl_MULT, ctrl_DIV}, 0);
      chk("rst_wbv",   wb_valid, 0);
      chk("rst_wbrd",  wb_rd, 0);
      chk("rst_wbdat", wb_data, 0);

      // mul $5, ready on BUSY 4, result 42
      clear_prog();
      add_op(mk(5'd0, 5'd5, 5'b00110), 4, 1'b0, 32'd42, 0);
      run(10);
      chk("t1_stall",  stall_tr, 64'h1F);
      chk("t1_mult",   mul_tr, 64'h2);
      chk("t1_div",    div_tr, 0);
      chk("t1_wbv",    wbv_tr, 64'h20);
      chk("t1_wbrd",   rd_tr[5], 5);
      chk("t1_wbdat",  dat_tr[5], 42);

      // div $3, exception on BUSY 3
      clear_prog();
      add_op(mk(5'd0, 5'd3, 5'b00111), 3, 1'b1, 32'h1234, 0);
      run(8);
      chk("t2_div",    div_tr, 64'h2);
      chk("t2_mult",   mul_tr, 0);
      chk("t2_stall",  stall_tr, 64'hF);
      chk("t2_wbv",    wbv_tr, 64'h10);
      chk("t2_wbrd",   rd_tr[4], 30);
      chk("t2_wbdat",  dat_tr[4], 5);

      // mul, md_ready never comes: 40 BUSY cycles + issue
      clear_prog();
      add_op(mk(5'd0, 5'd8, 5'b00110), 0, 1'b0, 32'd0, 0);
      run(46);
      chk("t3_stallcnt", $countones(stall_tr), 41);
      chk("t3_stall40",  stall_tr[40], 1);
      chk("t3_wbv",      wbv_tr, 64'h1 << 41);
      chk("t3_wbrd",     rd_tr[41], 30);
      chk("t3_wbdat",    dat_tr[41], 4);

      // mul, flush on BUSY 2, late md_ready on BUSY 4
      clear_prog();
      add_op(mk(5'd0, 5'd5, 5'b00110), 4, 1'b0, 32'd77, 2);
      run(10);
      chk("t4_stall",  stall_tr, 64'h7);
      chk("t4_mult",   mul_tr, 64'h2);
      chk("t4_wbv",    wbv_tr, 0);
      chk("t4_hold",   {27'd0, rd_tr[9], dat_tr[9]}, {27'd0, 5'd30, 32'd4});

      // add, mul $7 (BUSY 2, 99), div $9 (BUSY 3, 3), addi with mul-like ALU bits
      clear_prog();
      add_op(mk(5'd0, 5'd2, 5'b00000), 0, 1'b0, 32'd0, 0);
      add_op(mk(5'd0, 5'd7, 5'b00110), 2, 1'b0, 32'd99, 0);
      add_op(mk(5'd0, 5'd9, 5'b00111), 3, 1'b0, 32'd3, 0);
      add_op(mk(5'd5, 5'd4, 5'b00110), 0, 1'b0, 32'd0, 0);
      run(14);
      chk("t5_stall",  stall_tr, 64'h1EE);
      chk("t5_mult",   mul_tr, 64'h4);
      chk("t5_div",    div_tr, 64'h40);
      chk("t5_both",   mul_tr & div_tr, 0);
      chk("t5_wbv",    wbv_tr, 64'h210);
      chk("t5_wb1",    {rd_tr[4], dat_tr[4]}, {5'd7, 32'd99});
      chk("t5_wb2",    {rd_tr[9], dat_tr[9]}, {5'd9, 32'd3});

      // reset on BUSY 2 of a mul, then mul $0 (BUSY 2, 7)
      clear_prog();
      add_op(mk(5'd0, 5'd5, 5'b00110), 4, 1'b0, 32'd42, 0);
      rst_at = 2;
      run(8);
      chk("t6_outs",   {stall_tr[3], mul_tr[3], div_tr[3], wbv_tr[3]}, 0);
      chk("t6_wbrd",   rd_tr[3], 0);
      chk("t6_wbdat",  dat_tr[3], 0);
      chk("t6_wbv",    wbv_tr, 0);
      chk("t6_stall",  stall_tr, 64'h7);
      clear_prog();
      add_op(mk(5'd0, 5'd0, 5'b00110), 2, 1'b0, 32'd7, 0);
      run(6);
      chk("t7_mult",   mul_tr, 64'h2);
      chk("t7_stall",  stall_tr, 64'h7);
      chk("t7_wbv",    wbv_tr, 64'h8);
      chk("t7_wb",     {rd_tr[3], dat_tr[3]}, {5'd0, 32'd7});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
